// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------
// imm_gen_stage
//
// Registered immediate-generation stage sitting between instruction fetch and
// the execute/ALU operand mux. Each accepted 32-bit MIPS instruction is decoded
// combinationally into an immediate value, an immediate kind and its register
// fields. The result is then captured in a single output register that uses a
// valid/ready handshake. A saturating counter tracks accepted illegal opcodes
// for debug.
//
// Parameters
//   size   output immediate width (only 32 is meaningful for MIPS words)
//   CNT_W  width of the saturating illegal-opcode counter
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   flush          drop the held / incoming instruction this edge
//   in_valid       instr_in carries a valid word
//   in_ready       stage can accept a word this cycle (combinational)
//   instr_in       instruction word
//   out_valid      output register holds a valid result
//   out_ready      consumer accepts the result this cycle
//   imm_out        generated immediate
//   imm_kind       0=NONE 1=SEXT 2=ZEXT 3=LUI 4=BRANCH 5=JUMP
//   opcode_out     instr[31:26]
//   rs_out         instr[25:21]
//   rt_out         instr[20:16]
//   rd_out         instr[15:11]
//   illegal        registered opcode was unrecognised
//   illegal_count  saturating count of accepted, non-flushed illegal words
// ---------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int size  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [size-1:0]  imm_out,
    output logic [2:0]       imm_kind,
    output logic [5:0]       opcode_out,
    output logic [4:0]       rs_out,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // The decode formulas below produce 32-bit words, so no other width is
    // accepted.
    generate
        if (size != 32) begin : g_size_check
            $error("imm_gen_stage: parameter size must be 32");
        end
    endgenerate

    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_SEXT   = 3'd1;
    localparam logic [2:0] KIND_ZEXT   = 3'd2;
    localparam logic [2:0] KIND_LUI    = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JUMP   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction fields
    logic [5:0]  opcode_s;
    logic [15:0] imm16_s;
    logic [25:0] target_s;

    // Combinational decode results
    logic [31:0] dec_imm_s;
    logic [2:0]  dec_kind_s;
    logic        dec_illegal_s;

    // Handshake
    logic        in_ready_s;
    logic        accept_s;
    logic        consume_s;

    // Output register
    logic             out_valid_r;
    logic [31:0]      imm_r;
    logic [2:0]       kind_r;
    logic [5:0]       opcode_r;
    logic [4:0]       rs_r;
    logic [4:0]       rt_r;
    logic [4:0]       rd_r;
    logic             illegal_r;
    logic [CNT_W-1:0] illegal_count_r;

    assign opcode_s = instr_in[31:26];
    assign imm16_s  = instr_in[15:0];
    assign target_s = instr_in[25:0];

    // Opcode classification and immediate formation
    always_comb begin
        dec_imm_s     = 32'h0000_0000;
        dec_kind_s    = KIND_NONE;
        dec_illegal_s = 1'b0;
        case (opcode_s)
            6'b001111: begin // LUI
                dec_imm_s  = {imm16_s, 16'h0000};
                dec_kind_s = KIND_LUI;
            end
            6'b001100, 6'b001101, 6'b001110: begin // ANDI ORI XORI
                dec_imm_s  = {16'h0000, imm16_s};
                dec_kind_s = KIND_ZEXT;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b100011, 6'b101011: begin // ADDI ADDIU SLTI SLTIU LW SW
                dec_imm_s  = {{16{imm16_s[15]}}, imm16_s};
                dec_kind_s = KIND_SEXT;
            end
            6'b000100, 6'b000101: begin // BEQ BNE: word offset in bytes
                dec_imm_s  = {{14{imm16_s[15]}}, imm16_s, 2'b00};
                dec_kind_s = KIND_BRANCH;
            end
            6'b000010, 6'b000011: begin // J JAL: 28-bit region target
                dec_imm_s  = {4'b0000, target_s, 2'b00};
                dec_kind_s = KIND_JUMP;
            end
            6'b000000: begin // R-type carries no immediate
                dec_imm_s  = 32'h0000_0000;
                dec_kind_s = KIND_NONE;
            end
            default: begin
                dec_imm_s     = 32'h0000_0000;
                dec_kind_s    = KIND_NONE;
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // A free slot exists when the register is empty or is being drained now.
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign consume_s  = out_valid_r && out_ready;

    // Output pipeline register: flush wins over accept, accept over consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            imm_r       <= 32'h0000_0000;
            kind_r      <= KIND_NONE;
            opcode_r    <= 6'd0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            rd_r        <= 5'd0;
            illegal_r   <= 1'b0;
        end else if (flush) begin
            // Data fields intentionally left stale; only validity is dropped.
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            imm_r       <= dec_imm_s;
            kind_r      <= dec_kind_s;
            opcode_r    <= opcode_s;
            rs_r        <= instr_in[25:21];
            rt_r        <= instr_in[20:16];
            rd_r        <= instr_in[15:11];
            illegal_r   <= dec_illegal_s;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of illegal words that actually enter the register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_count_r <= {CNT_W{1'b0}};
        end else if (accept_s && !flush && dec_illegal_s &&
                     (illegal_count_r != CNT_MAX)) begin
            illegal_count_r <= illegal_count_r + CNT_ONE;
        end else begin
            illegal_count_r <= illegal_count_r;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_r;
    assign imm_out       = imm_r;
    assign imm_kind      = kind_r;
    assign opcode_out    = opcode_r;
    assign rs_out        = rs_r;
    assign rt_out        = rt_r;
    assign rd_out        = rd_r;
    assign illegal       = illegal_r;
    assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_imm_gen_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_stage
//
// Self-checking bench for imm_gen_stage. The expected register contents come
// from a reference model. That model computes immediates arithmetically from
// the MIPS opcode table and tracks the output slot at transaction level.
// Directed cases come first, followed by a randomized handshake/flush run.
// ---------------------------------------------------------------------------
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [2:0]  imm_kind;
    logic [5:0]  opcode_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic        illegal;
    logic [7:0]  illegal_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the output slot should hold
    logic        m_valid;
    logic [31:0] m_imm;
    logic [2:0]  m_kind;
    logic [5:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_ill;
    int          m_cnt;

    always #5 clk = ~clk;

    imm_gen_stage #(.size(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .imm_kind(imm_kind), .opcode_out(opcode_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Kind from the MIPS opcode table
    function automatic logic [2:0] ref_kind(input logic [5:0] op);
        case (op)
            6'h0F:                                    return 3'd3;
            6'h0C, 6'h0D, 6'h0E:                      return 3'd2;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: return 3'd1;
            6'h04, 6'h05:                             return 3'd4;
            6'h02, 6'h03:                             return 3'd5;
            default:                                  return 3'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [5:0] op);
        return (op != 6'h00) && (ref_kind(op) == 3'd0);
    endfunction

    // Immediate computed with integer arithmetic instead of bit concatenation
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int          s;
        logic [31:0] u16;
        logic [31:0] t26;
        s   = $signed(ins[15:0]);
        u16 = 32'(ins[15:0]);
        t26 = 32'(ins[25:0]);
        case (ref_kind(ins[31:26]))
            3'd3:    return u16 * 32'd65536;
            3'd2:    return u16;
            3'd1:    return 32'(s);
            3'd4:    return 32'(s * 4);
            3'd5:    return t26 * 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".count"}, 32'(illegal_count), 32'(m_cnt));
        if (m_valid) begin
            check({tag, ".imm"}, imm_out, m_imm);
            check({tag, ".kind"}, 32'(imm_kind), 32'(m_kind));
            check({tag, ".opcode"}, 32'(opcode_out), 32'(m_op));
            check({tag, ".rs"}, 32'(rs_out), 32'(m_rs));
            check({tag, ".rt"}, 32'(rt_out), 32'(m_rt));
            check({tag, ".rd"}, 32'(rd_out), 32'(m_rd));
            check({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
        end
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, then advance
    // the model across the edge and compare the registered outputs.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic acc;
        logic con;
        in_valid  = v;
        instr_in  = ins;
        out_ready = ordy;
        flush     = fl;
        #2;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        con = m_valid && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_imm   = ref_imm(ins);
            m_kind  = ref_kind(ins[31:26]);
            m_op    = ins[31:26];
            m_rs    = ins[25:21];
            m_rt    = ins[20:16];
            m_rd    = ins[15:11];
            m_ill   = ref_illegal(ins[31:26]);
            if (m_ill && m_cnt < 255) m_cnt++;
        end else if (con) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    logic [5:0] op_pool [18] = '{6'h0F, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05,
                                 6'h02, 6'h03, 6'h00, 6'h3F, 6'h11, 6'h20};

    initial begin
        logic [31:0] r;
        logic [5:0]  op;

        // Reset held two cycles while a valid LUI is presented
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
        instr_in = 32'h3C01_ABCD; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.imm", imm_out, 32'd0);
        check("rst.kind", 32'(imm_kind), 32'd0);
        check("rst.opcode", 32'(opcode_out), 32'd0);
        check("rst.regs", {17'd0, rs_out, rt_out, rd_out}, 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.count", 32'(illegal_count), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        m_valid = 1'b0; m_imm = 32'd0; m_kind = 3'd0; m_op = 6'd0;
        m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_ill = 1'b0; m_cnt = 0;
        rst_n = 1'b1;

        step("lui", 1'b1, 32'h3C01_ABCD, 1'b0, 1'b0);
        check("lui.imm_const", imm_out, 32'hABCD_0000);
        check("lui.kind_const", 32'(imm_kind), 32'd3);
        check("lui.rt_const", 32'(rt_out), 32'd1);

        // Back-to-back stream
        step("ori", 1'b1, 32'h3421_8001, 1'b1, 1'b0);
        check("ori.imm_const", imm_out, 32'h0000_8001);
        check("ori.kind_const", 32'(imm_kind), 32'd2);
        step("addi", 1'b1, 32'h2021_8001, 1'b1, 1'b0);
        check("addi.imm_const", imm_out, 32'hFFFF_8001);
        check("addi.kind_const", 32'(imm_kind), 32'd1);
        step("beq", 1'b1, 32'h1022_FFFF, 1'b1, 1'b0);
        check("beq.imm_const", imm_out, 32'hFFFF_FFFC);
        check("beq.kind_const", 32'(imm_kind), 32'd4);
        check("beq.valid_const", 32'(out_valid), 32'd1);

        // Backpressure: held BEQ must not change, J must not load early
        for (int i = 0; i < 4; i++) begin
            step("stall", 1'b1, 32'h0810_0004, 1'b0, 1'b0);
            check("stall.in_ready_const", 32'(in_ready), 32'd0);
            check("stall.imm_hold", imm_out, 32'hFFFF_FFFC);
        end
        step("jump", 1'b1, 32'h0810_0004, 1'b1, 1'b0);
        check("jump.imm_const", imm_out, 32'h0040_0010);
        check("jump.kind_const", 32'(imm_kind), 32'd5);

        step("rtype", 1'b1, 32'h0022_1820, 1'b1, 1'b0);
        check("rtype.imm_const", imm_out, 32'd0);
        check("rtype.rd_const", 32'(rd_out), 32'd3);
        check("rtype.illegal_const", 32'(illegal), 32'd0);

        // Illegal opcode saturation
        for (int i = 0; i < 300; i++) begin
            step("illegal", 1'b1, 32'hFC00_0000, 1'b1, 1'b0);
        end
        check("sat.illegal_const", 32'(illegal), 32'd1);
        check("sat.count_const", 32'(illegal_count), 32'd255);
        step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        step("flush_ill", 1'b1, 32'hFC00_0000, 1'b1, 1'b1);
        check("flush.valid_const", 32'(out_valid), 32'd0);
        check("flush.count_const", 32'(illegal_count), 32'd255);

        // Re-reset so the counter can be exercised below saturation
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst2.count", 32'(illegal_count), 32'd0);
        check("rst2.out_valid", 32'(out_valid), 32'd0);
        m_valid = 1'b0; m_cnt = 0;
        rst_n = 1'b1;

        // Randomized mix of opcodes, handshakes and occasional flushes
        for (int i = 0; i < 600; i++) begin
            r  = $urandom;
            op = op_pool[$urandom_range(0, 17)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            step("rand", 1'($urandom_range(0, 3) != 0), {op, r[25:0]},
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
